// File: rtl/imm_extract_stage_if.sv
// ============================================================================
// Module      : imm_extract_stage_if
// Description : Handshake bus of the immediate-generation stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imm_extract_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) ();
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [31:0]       instruction_i;
  logic [2:0]        selection_i;
  logic [TAG_W-1:0]  tag_i;
  logic              valid_o;
  logic              ready_i;
  logic [XLEN-1:0]   value_o;
  logic [TAG_W-1:0]  tag_o;
  logic              illegal_o;

  // Stage-side view.
  modport slave (
    input  flush_i, valid_i, instruction_i, selection_i, tag_i, ready_i,
    output ready_o, valid_o, value_o, tag_o, illegal_o
  );

  // Producer/consumer-side view.
  modport master (
    output flush_i, valid_i, instruction_i, selection_i, tag_i, ready_i,
    input  ready_o, valid_o, value_o, tag_o, illegal_o
  );
endinterface

`default_nettype wire

// File: rtl/imm_extract_stage.sv
// ============================================================================
// Module      : imm_extract_stage
// Description : Registered RV32 immediate generator with a 2-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extract_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  imm_extract_stage_if.slave bus
);

  localparam logic [2:0] c_sel_r = 3'd0;
  localparam logic [2:0] c_sel_i = 3'd1;
  localparam logic [2:0] c_sel_u = 3'd2;
  localparam logic [2:0] c_sel_s = 3'd3;
  localparam logic [2:0] c_sel_b = 3'd4;
  localparam logic [2:0] c_sel_j = 3'd5;
  localparam logic [2:0] c_sel_z = 3'd6;

  logic [31:0]      w_instr;
  logic [31:0]      w_imm32;
  logic [XLEN-1:0]  w_imm;
  logic             w_illegal;

  logic             w_accept;
  logic             w_out_free;
  logic             w_out_valid_nxt;
  logic             w_sk_valid_nxt;
  logic             w_load_out_from_sk;
  logic             w_load_out_from_in;
  logic             w_load_sk;

  logic             r_ready;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_value;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_illegal;
  logic             r_sk_valid;
  logic [XLEN-1:0]  r_sk_value;
  logic [TAG_W-1:0] r_sk_tag;
  logic             r_sk_illegal;

  assign w_instr = bus.instruction_i;

  // Every format fits in 32 bits with bit 31 as the sign; Z, R and the
  // reserved code all produce bit 31 = 0, so one sign extension serves all.
  always_comb begin
    w_imm32   = '0;
    w_illegal = 1'b0;
    case (bus.selection_i)
      c_sel_r: w_imm32 = '0;
      c_sel_i: w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
      c_sel_u: w_imm32 = {w_instr[31:12], 12'b0};
      c_sel_s: w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      c_sel_b: w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                          w_instr[30:25], w_instr[11:8], 1'b0};
      c_sel_j: w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                          w_instr[20], w_instr[30:21], 1'b0};
      c_sel_z: w_imm32 = {27'b0, w_instr[19:15]};
      default: begin
        w_imm32   = '0;
        w_illegal = 1'b1;
      end
    endcase
  end

  generate
    if (XLEN == 64) begin : g_ext64
      assign w_imm = {{32{w_imm32[31]}}, w_imm32};
    end else begin : g_ext32
      assign w_imm = w_imm32;
    end
  endgenerate

  assign w_accept   = bus.valid_i & r_ready;
  assign w_out_free = ~r_out_valid | bus.ready_i;

  // A valid skid entry always wins the output slot; ready_o is low while it
  // is held, so an accept can never coincide with a skid-to-output move.
  always_comb begin
    w_out_valid_nxt    = r_out_valid;
    w_sk_valid_nxt     = r_sk_valid;
    w_load_out_from_sk = 1'b0;
    w_load_out_from_in = 1'b0;
    w_load_sk          = 1'b0;
    if (bus.flush_i) begin
      w_out_valid_nxt = 1'b0;
      w_sk_valid_nxt  = 1'b0;
    end else if (w_out_free) begin
      if (r_sk_valid) begin
        w_load_out_from_sk = 1'b1;
        w_out_valid_nxt    = 1'b1;
        w_sk_valid_nxt     = 1'b0;
      end else if (w_accept) begin
        w_load_out_from_in = 1'b1;
        w_out_valid_nxt    = 1'b1;
      end else begin
        w_out_valid_nxt    = 1'b0;
      end
    end else if (w_accept) begin
      w_load_sk      = 1'b1;
      w_sk_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_sk_valid  <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      r_sk_valid  <= w_sk_valid_nxt;
      r_ready     <= ~w_sk_valid_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_value   <= '0;
      r_out_tag     <= '0;
      r_out_illegal <= 1'b0;
    end else if (w_load_out_from_sk) begin
      r_out_value   <= r_sk_value;
      r_out_tag     <= r_sk_tag;
      r_out_illegal <= r_sk_illegal;
    end else if (w_load_out_from_in) begin
      r_out_value   <= w_imm;
      r_out_tag     <= bus.tag_i;
      r_out_illegal <= w_illegal;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sk_value   <= '0;
      r_sk_tag     <= '0;
      r_sk_illegal <= 1'b0;
    end else if (w_load_sk) begin
      r_sk_value   <= w_imm;
      r_sk_tag     <= bus.tag_i;
      r_sk_illegal <= w_illegal;
    end
  end

  assign bus.ready_o   = r_ready;
  assign bus.valid_o   = r_out_valid;
  assign bus.value_o   = r_out_value;
  assign bus.tag_o     = r_out_tag;
  assign bus.illegal_o = r_out_illegal;

endmodule

`default_nettype wire

// File: tb/tb_imm_extract_stage.sv
// ============================================================================
// Module      : tb_imm_extract_stage
// Description : Directed self-checking bench for imm_extract_stage (XLEN 32/64).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_extract_stage;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  imm_extract_stage_if #(.XLEN(32), .TAG_W(32)) if32 ();
  imm_extract_stage_if #(.XLEN(64), .TAG_W(8))  if64 ();

  imm_extract_stage #(.XLEN(32), .TAG_W(32)) u_dut32 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if32.slave)
  );

  imm_extract_stage #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] tag;
    logic [31:0] exp_val;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [31:0] instr, input logic [2:0] sel,
                         input logic [31:0] tag);
    if32.valid_i       = v;
    if32.instruction_i = instr;
    if32.selection_i   = sel;
    if32.tag_i         = tag;
  endtask

  task automatic check_out32(input string name, input logic [31:0] val, input logic [31:0] tag,
                             input logic ill);
    check({name, ".valid"},   {63'b0, if32.valid_o},   64'd1);
    check({name, ".value"},   {32'b0, if32.value_o},   {32'b0, val});
    check({name, ".tag"},     {32'b0, if32.tag_o},     {32'b0, tag});
    check({name, ".illegal"}, {63'b0, if32.illegal_o}, {63'b0, ill});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{32'hFFF00093, 3'd1, 32'h10, 32'hFFFFFFFF, 1'b0};
    vecs[1] = '{32'h123452B7, 3'd2, 32'h11, 32'h12345000, 1'b0};
    vecs[2] = '{32'hFE512C23, 3'd3, 32'h12, 32'hFFFFFFF8, 1'b0};
    vecs[3] = '{32'hFE000EE3, 3'd4, 32'h13, 32'hFFFFFFFC, 1'b0};
    vecs[4] = '{32'h0010006F, 3'd5, 32'h14, 32'h00000800, 1'b0};
    vecs[5] = '{32'h800FD073, 3'd6, 32'h15, 32'h0000001F, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 3'd7, 32'h16, 32'h00000000, 1'b1};
    vecs[7] = '{32'hFFFFFFFF, 3'd0, 32'h17, 32'h00000000, 1'b0};

    rst = 1'b1;
    if32.flush_i = 1'b0;
    if32.ready_i = 1'b1;
    drive32(1'b0, 32'h0, 3'd0, 32'h0);
    if64.flush_i       = 1'b0;
    if64.ready_i       = 1'b1;
    if64.valid_i       = 1'b0;
    if64.instruction_i = 32'h0;
    if64.selection_i   = 3'd0;
    if64.tag_i         = 8'h0;

    #2;
    check("rst.valid",   {63'b0, if32.valid_o},   64'd0);
    check("rst.ready",   {63'b0, if32.ready_o},   64'd1);
    check("rst.value",   {32'b0, if32.value_o},   64'd0);
    check("rst.tag",     {32'b0, if32.tag_o},     64'd0);
    check("rst.illegal", {63'b0, if32.illegal_o}, 64'd0);
    step();
    rst = 1'b0;
    step();

    // Back-to-back stream, one word per cycle.
    for (int i = 0; i < 8; i++) begin
      drive32(1'b1, vecs[i].instr, vecs[i].sel, vecs[i].tag);
      step();
      check_out32($sformatf("vec%0d", i), vecs[i].exp_val, vecs[i].tag, vecs[i].exp_ill);
      check($sformatf("vec%0d.ready", i), {63'b0, if32.ready_o}, 64'd1);
    end
    drive32(1'b0, 32'h0, 3'd0, 32'h0);
    step();
    check("drain.valid", {63'b0, if32.valid_o}, 64'd0);

    // XLEN=64 extension.
    if64.valid_i = 1'b1; if64.instruction_i = 32'h800002B7; if64.selection_i = 3'd2; if64.tag_i = 8'hA1;
    step();
    check("x64.u.value", if64.value_o, 64'hFFFFFFFF80000000);
    check("x64.u.tag",   {56'b0, if64.tag_o}, 64'hA1);
    if64.instruction_i = 32'hFFF00093; if64.selection_i = 3'd1; if64.tag_i = 8'hA2;
    step();
    check("x64.i.value", if64.value_o, 64'hFFFFFFFFFFFFFFFF);
    check("x64.i.valid", {63'b0, if64.valid_o}, 64'd1);
    if64.valid_i = 1'b0;
    step();

    // Backpressure: A in OUT, B in skid, C held by source.
    if32.ready_i = 1'b0;
    drive32(1'b1, 32'hFFF00093, 3'd1, 32'd1);
    step();
    check_out32("bp.A0", 32'hFFFFFFFF, 32'd1, 1'b0);
    check("bp.ready0", {63'b0, if32.ready_o}, 64'd1);
    drive32(1'b1, 32'h123452B7, 3'd2, 32'd2);
    step();
    check_out32("bp.A1", 32'hFFFFFFFF, 32'd1, 1'b0);
    check("bp.ready1", {63'b0, if32.ready_o}, 64'd0);
    drive32(1'b1, 32'h800FD073, 3'd6, 32'd3);
    step();
    check_out32("bp.A2", 32'hFFFFFFFF, 32'd1, 1'b0);
    check("bp.ready2", {63'b0, if32.ready_o}, 64'd0);
    if32.ready_i = 1'b1;
    step();
    check_out32("bp.B", 32'h12345000, 32'd2, 1'b0);
    check("bp.ready3", {63'b0, if32.ready_o}, 64'd1);
    step();
    check_out32("bp.C", 32'h0000001F, 32'd3, 1'b0);
    drive32(1'b0, 32'h0, 3'd0, 32'h0);
    step();
    check("bp.end.valid", {63'b0, if32.valid_o}, 64'd0);

    // Flush with both entries full and a word on offer.
    if32.ready_i = 1'b0;
    drive32(1'b1, 32'hFFF00093, 3'd1, 32'd4);
    step();
    drive32(1'b1, 32'h123452B7, 3'd2, 32'd5);
    step();
    check("fl.pre.ready", {63'b0, if32.ready_o}, 64'd0);
    drive32(1'b1, 32'hFE512C23, 3'd3, 32'd6);
    if32.flush_i = 1'b1;
    step();
    if32.flush_i = 1'b0;
    check("fl.valid", {63'b0, if32.valid_o}, 64'd0);
    check("fl.ready", {63'b0, if32.ready_o}, 64'd1);
    if32.ready_i = 1'b1;
    drive32(1'b1, 32'h0010006F, 3'd5, 32'd9);
    step();
    check_out32("fl.next", 32'h00000800, 32'd9, 1'b0);
    drive32(1'b0, 32'h0, 3'd0, 32'h0);
    step();
    check("fl.end.valid", {63'b0, if32.valid_o}, 64'd0);

    // Asynchronous reset between edges with both entries full.
    if32.ready_i = 1'b0;
    drive32(1'b1, 32'hFFF00093, 3'd1, 32'd7);
    step();
    drive32(1'b1, 32'h123452B7, 3'd2, 32'd8);
    step();
    drive32(1'b0, 32'h0, 3'd0, 32'h0);
    #3 rst = 1'b1;
    #1;
    check("arst.valid", {63'b0, if32.valid_o}, 64'd0);
    check("arst.value", {32'b0, if32.value_o}, 64'd0);
    check("arst.tag",   {32'b0, if32.tag_o},   64'd0);
    check("arst.ready", {63'b0, if32.ready_o}, 64'd1);
    #1 rst = 1'b0;
    if32.ready_i = 1'b1;
    step();
    check("arst.resid", {63'b0, if32.valid_o}, 64'd0);
    drive32(1'b1, 32'hFE000EE3, 3'd4, 32'd12);
    step();
    check_out32("arst.next", 32'hFFFFFFFC, 32'd12, 1'b0);
    drive32(1'b0, 32'h0, 3'd0, 32'h0);
    step();
    check("arst.end.valid", {63'b0, if32.valid_o}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
